irq_controller_6502: RTL and testbench
======================================

Name: irq_controller_6502

Overview:
- Memory-mapped interrupt controller for the 6502 system. It replaces the tied-off irq/nmi inputs of ag6502.
- Collects up to 8 external interrupt sources (buttons, timers, peripherals) and applies per-source masking, edge/level mode and polarity.
- Drives the CPU irq line from the masked pending set, and drives nmi from one dedicated source.
- Sits on the CPU data bus in the I/O page at 0x2030-0x2037. The system decodes the page and supplies sel plus addr[2:0]; read data is muxed into cpu_din.

Parameters:
- N_SRC, 8, number of maskable interrupt sources (1..8).
- SYNC_STAGES, 2, synchronizer flops per source input (>=2).

Ports:
- clk  in  1  system clock (the CPU clock).
- reset_  in  1  asynchronous, active-low reset.
- sel  in  1  register-window select (cpu_addr[15:3] == 0x2030>>3).
- addr  in  3  register offset.
- din  in  8  write data (cpu_dout).
- dout  out  8  read data, combinational from addr and register state; 0x00 when sel=0.
- we  in  1  write strobe (~rdwr_); a write occurs on the clk rising edge with sel&we.
- src  in  N_SRC  asynchronous interrupt source inputs.
- nmi_src  in  1  asynchronous NMI source input.
- irq  out  1  to CPU; 1 = interrupt requested.
- nmi  out  1  to CPU; 1 = NMI requested.

Behaviour:
- Register map:
  - 0 PEND: R = pending bits. W = write-1-to-clear.
  - 1 MASK: R/W, 1 = enabled.
  - 2 MODE: R/W, 1 = edge, 0 = level.
  - 3 POL: R/W, 1 = active-low/falling edge.
  - 4 VECT: R only. [2:0] = lowest-numbered pending&MASK source, bit7 = 1 when none; writes ignored.
  - 5 CTRL: R/W. bit0 = global IRQ enable, bit1 = NMI enable, others read 0.
  - 6 NMIST: bit0 = NMI latched, write-1-to-clear.
  - 7: reads 0x00, writes ignored.
- Reset (async, reset_=0): PEND, MASK, MODE, POL, CTRL, NMIST and all synchronizer/edge flops = 0. irq=0, nmi=0, dout=0x00 (sel irrelevant).
- Input path:
  - src[i] passes SYNC_STAGES flops, then XOR with POL[i] to give act[i].
  - Edge mode: a 0->1 transition of act[i] sets PEND[i] on the next edge. Latency from a src change to PEND set = SYNC_STAGES+1 clocks.
  - Level mode: PEND[i] = act[i] every cycle. W1C has no lasting effect while the source stays active.
- Simultaneous edge event and W1C on the same bit in the same cycle: set wins (the event is never lost).
- MODE/POL change: the edge detector's previous-value flop keeps tracking act. A polarity flip that produces an apparent rising edge sets PEND; software clears it.
- Outputs:
  - irq = CTRL[0] & |(PEND & MASK), registered, one clock after PEND/MASK/CTRL change. Deasserts one clock after the last masked pending bit clears.
  - nmi_src is synchronized like src, with rising-edge only and no polarity. It sets NMIST[0] when CTRL[1]=1. nmi = NMIST[0], registered.
  - NMI edge and W1C on the same cycle: set wins. Further NMI edges while NMIST=1 are absorbed.
- Reads have no side effects; reading VECT does not acknowledge.
- Bits >= N_SRC in PEND/MASK/MODE/POL read 0 and ignore writes.
- Mid-operation reset clears everything asynchronously. The synchronizer restarts, so a source that is high when reset deasserts is treated as an edge (it was 0 in reset) in edge mode.

Decomposition:
- Shared package: register offset constants (REG_PEND..REG_NMIST), CTRL bit indices, VECT_NONE = 8'h80, base address 16'h2030.
- Sub-module irq_sync_edge (SYNC_STAGES synchronizer + previous flop; outputs level and rise). It is instantiated N_SRC+1 times via generate.

Test Plan:
- Reset: hold reset_=0 with src=0xFF -> all register reads 0x00 after release, VECT=0x80, irq=0, nmi=0. Assert reset_ mid-IRQ -> irq drops immediately (async).
- Edge mode: MODE=0xFF, MASK=0x04, CTRL=0x01, pulse src[2] high for 1 clk -> PEND=0x04 after 3 clks, irq=1 one clk later, VECT=0x02. Write PEND=0x04 -> irq=0 next clk.
- Level+polarity: MODE=0, POL=0x01, MASK=0x01, CTRL=0x01, src[0]=0 -> PEND[0]=1, irq=1. W1C while src[0]=0 -> PEND stays 1. src[0]=1 -> PEND clears after 3 clks, irq=0 a clk later.
- Priority/mask: edges on src[5] and src[3], MASK=0x20 -> VECT=0x05, PEND=0x28. Set MASK=0x28 -> VECT=0x03. CTRL=0x00 -> irq=0 while PEND is unchanged.
- Collision: a src[1] rising edge reaches the edge detector on the same clk as a W1C of PEND bit1 -> PEND[1]=1 afterwards. The same case on NMI -> NMIST=1.
- NMI: CTRL=0x02, rise on nmi_src -> nmi=1 four clks later. A second rise does not change the state. Write NMIST=0x01 -> nmi=0. With CTRL[1]=0, a rise gives NMIST=0.

Source files
------------

// File: rtl/irq_controller_6502_pkg.sv
// irq_controller_6502_pkg: register map, control bit positions and vector helper
// shared by the 6502 interrupt controller.
package irq_controller_6502_pkg;

    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MASK  = 3'd1;
    localparam logic [2:0] REG_MODE  = 3'd2;
    localparam logic [2:0] REG_POL   = 3'd3;
    localparam logic [2:0] REG_VECT  = 3'd4;
    localparam logic [2:0] REG_CTRL  = 3'd5;
    localparam logic [2:0] REG_NMIST = 3'd6;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_NMI_EN = 1;

    localparam logic [7:0]  VECT_NONE = 8'h80;
    localparam logic [15:0] BASE_ADDR = 16'h2030;

    // Lowest-numbered set bit wins; VECT_NONE when nothing is set.
    function automatic logic [7:0] vect_of(input logic [7:0] m);
        vect_of = VECT_NONE;
        for (int i = 7; i >= 0; i--)
            if (m[i]) vect_of = {5'd0, 3'(i)};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: synchronizer chain plus previous-value flop for one interrupt input;
// emits the active level in level mode or a one-cycle rise pulse in edge mode.
module irq_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_,
    input  logic d_i,
    input  logic inv_i,
    input  logic edge_i,
    output logic ev_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              act;

    assign act  = sync_q[STAGES-1] ^ inv_i;
    assign ev_o = edge_i ? (act & ~prev_q) : act;

    // prev_q tracks act in both modes so a mode or polarity change sees the true history
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= act;
        end
    end

endmodule

// File: rtl/irq_controller_6502.sv
// irq_controller_6502: memory-mapped IRQ/NMI controller with per-source mask,
// edge/level mode and polarity, driving the 6502 irq and nmi lines.
module irq_controller_6502
    import irq_controller_6502_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             sel,
    input  logic [2:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic             we,
    input  logic [N_SRC-1:0] src,
    input  logic             nmi_src,
    output logic             irq,
    output logic             nmi
);

    localparam logic [7:0] VALID = 8'hFF >> (8 - N_SRC);

    logic [7:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d, pol_q, pol_d, ev;
    logic [1:0] ctrl_q, ctrl_d;
    logic       nmist_q, nmist_d, irq_q, nmi_q, nmi_rise, wr;

    for (genvar g = 0; g < 8; g++) begin : g_src
        if (g < N_SRC) begin : g_on
            irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
                .clk    (clk),
                .reset_ (reset_),
                .d_i    (src[g]),
                .inv_i  (pol_q[g]),
                .edge_i (mode_q[g]),
                .ev_o   (ev[g])
            );
        end else begin : g_off
            assign ev[g] = 1'b0;
        end
    end

    irq_sync_edge #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk    (clk),
        .reset_ (reset_),
        .d_i    (nmi_src),
        .inv_i  (1'b0),
        .edge_i (1'b1),
        .ev_o   (nmi_rise)
    );

    // ev is the level in level mode and the rise pulse in edge mode, so set beats clear
    always_comb begin
        wr      = sel & we;
        pend_d  = ((mode_q & pend_q & ~((wr && addr == REG_PEND) ? din : 8'h00)) | ev) & VALID;
        mask_d  = (wr && addr == REG_MASK) ? (din & VALID) : mask_q;
        mode_d  = (wr && addr == REG_MODE) ? (din & VALID) : mode_q;
        pol_d   = (wr && addr == REG_POL)  ? (din & VALID) : pol_q;
        ctrl_d  = (wr && addr == REG_CTRL) ? din[1:0] : ctrl_q;
        nmist_d = (nmist_q & ~(wr && addr == REG_NMIST && din[0])) | (nmi_rise & ctrl_q[CTRL_NMI_EN]);
    end

    always_comb begin
        dout = 8'h00;
        if (sel && reset_) begin
            case (addr)
                REG_PEND:  dout = pend_q;
                REG_MASK:  dout = mask_q;
                REG_MODE:  dout = mode_q;
                REG_POL:   dout = pol_q;
                REG_VECT:  dout = vect_of(pend_q & mask_q);
                REG_CTRL:  dout = {6'd0, ctrl_q};
                REG_NMIST: dout = {7'd0, nmist_q};
                default:   dout = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            ctrl_q  <= '0;
            nmist_q <= 1'b0;
            irq_q   <= 1'b0;
            nmi_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            ctrl_q  <= ctrl_d;
            nmist_q <= nmist_d;
            irq_q   <= ctrl_q[CTRL_IRQ_EN] & |(pend_q & mask_q);
            nmi_q   <= nmist_q;
        end
    end

    assign irq = irq_q;
    assign nmi = nmi_q;

endmodule

// File: tb/tb_irq_controller_6502.sv
// tb_irq_controller_6502: directed stimulus with a delay-line reference model
// compared every cycle, plus hand-computed register/line expectations.
module tb_irq_controller_6502;

    logic       clk = 1'b0;
    logic       reset_ = 1'b1;
    logic       sel = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       we = 1'b0;
    logic [7:0] src = 8'h00;
    logic       nmi_src = 1'b0;
    logic       irq, nmi;

    int errors = 0;
    int checks = 0;

    irq_controller_6502 #(.N_SRC(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_  (reset_),
        .sel     (sel),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .we      (we),
        .src     (src),
        .nmi_src (nmi_src),
        .irq     (irq),
        .nmi     (nmi)
    );

    always #5 clk = ~clk;

    // Reference model: src is seen two clocks late (synchronizer), the edge detector
    // remembers the previous active value, registers react on the following clock.
    logic [7:0] m_pend = 0, m_mask = 0, m_mode = 0, m_pol = 0, m_ctrl = 0;
    logic       m_nmist = 0, m_irq = 0, m_nmi = 0;
    logic [7:0] h1 = 0, h2 = 0, pact = 0;
    logic       n1 = 0, n2 = 0, pn = 0;

    always @(posedge clk or negedge reset_) begin
        logic [7:0] act, rise, clr;
        logic       w, nrise;
        if (!reset_) begin
            m_pend = 0; m_mask = 0; m_mode = 0; m_pol = 0; m_ctrl = 0;
            m_nmist = 0; m_irq = 0; m_nmi = 0;
            h1 = 0; h2 = 0; pact = 0; n1 = 0; n2 = 0; pn = 0;
        end else begin
            w     = sel && we;
            act   = h2 ^ m_pol;
            rise  = act & ~pact;
            clr   = (w && addr == 3'd0) ? din : 8'h00;
            nrise = n2 && !pn;
            m_irq = m_ctrl[0] && ((m_pend & m_mask) != 0);
            m_nmi = m_nmist;
            for (int i = 0; i < 8; i++)
                m_pend[i] = m_mode[i] ? ((m_pend[i] && !clr[i]) || rise[i]) : act[i];
            m_nmist = (m_nmist && !(w && addr == 3'd6 && din[0])) || (nrise && m_ctrl[1]);
            if (w && addr == 3'd1) m_mask = din;
            if (w && addr == 3'd2) m_mode = din;
            if (w && addr == 3'd3) m_pol = din;
            if (w && addr == 3'd5) m_ctrl = din & 8'h03;
            pact = act; h2 = h1; h1 = src;
            pn = n2; n2 = n1; n1 = nmi_src;
        end
    end

    function automatic logic [7:0] m_read(input logic [2:0] a);
        logic [7:0] v;
        v = 8'h80;
        for (int i = 7; i >= 0; i--)
            if (m_pend[i] && m_mask[i]) v = 8'(i);
        case (a)
            3'd0: return m_pend;
            3'd1: return m_mask;
            3'd2: return m_mode;
            3'd3: return m_pol;
            3'd4: return v;
            3'd5: return m_ctrl;
            3'd6: return {7'd0, m_nmist};
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [7:0] exp_d;
        exp_d = (sel && reset_) ? m_read(addr) : 8'h00;
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL model_irq t=%0t got=%b exp=%b", $time, irq, m_irq);
        end
        checks++;
        if (nmi !== m_nmi) begin
            errors++;
            $display("FAIL model_nmi t=%0t got=%b exp=%b", $time, nmi, m_nmi);
        end
        checks++;
        if (dout !== exp_d) begin
            errors++;
            $display("FAIL model_dout t=%0t addr=%0d got=%h exp=%h", $time, addr, dout, exp_d);
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        sel = 1; we = 1; addr = a; din = d;
        tick(1);
        sel = 0; we = 0;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [7:0] exp);
        sel = 1; addr = a;
        #1;
        chk(name, dout, exp);
        sel = 0;
    endtask

    initial begin
        src = 8'hFF;
        #1 reset_ = 0;
        tick(3);
        reset_ = 1; src = 8'h00;
        for (int a = 0; a < 8; a++)
            rd("reset_reg", 3'(a), (a == 4) ? 8'h80 : 8'h00);
        chk("reset_irq", {7'd0, irq}, 8'h00);
        chk("reset_nmi", {7'd0, nmi}, 8'h00);

        wr(3'd2, 8'hFF); wr(3'd1, 8'h04); wr(3'd5, 8'h01);
        src = 8'h04; tick(1); src = 8'h00; tick(2);
        rd("edge_pend", 3'd0, 8'h04);
        chk("edge_irq_early", {7'd0, irq}, 8'h00);
        tick(1);
        chk("edge_irq", {7'd0, irq}, 8'h01);
        rd("edge_vect", 3'd4, 8'h02);
        wr(3'd0, 8'h04);
        rd("edge_w1c", 3'd0, 8'h00);
        tick(1);
        chk("edge_irq_clr", {7'd0, irq}, 8'h00);

        wr(3'd2, 8'h00); wr(3'd3, 8'h01); wr(3'd1, 8'h01); wr(3'd5, 8'h01);
        tick(1);
        chk("lvl_irq", {7'd0, irq}, 8'h01);
        rd("lvl_pend", 3'd0, 8'h01);
        wr(3'd0, 8'h01);
        rd("lvl_w1c_noeffect", 3'd0, 8'h01);
        src = 8'h01; tick(3);
        rd("lvl_pend_clr", 3'd0, 8'h00);
        chk("lvl_irq_hold", {7'd0, irq}, 8'h01);
        tick(1);
        chk("lvl_irq_clr", {7'd0, irq}, 8'h00);

        src = 8'h00; wr(3'd3, 8'h00); tick(4);
        wr(3'd2, 8'hFF); wr(3'd0, 8'hFF);
        rd("clean_pend", 3'd0, 8'h00);

        wr(3'd1, 8'h20);
        src = 8'h28; tick(1); src = 8'h00; tick(2);
        rd("prio_pend", 3'd0, 8'h28);
        rd("prio_vect5", 3'd4, 8'h05);
        tick(1);
        chk("prio_irq", {7'd0, irq}, 8'h01);
        wr(3'd1, 8'h28);
        rd("prio_vect3", 3'd4, 8'h03);
        wr(3'd5, 8'h00); tick(1);
        chk("ctrl_off_irq", {7'd0, irq}, 8'h00);
        rd("ctrl_off_pend", 3'd0, 8'h28);

        wr(3'd0, 8'h28);
        rd("coll_pre", 3'd0, 8'h00);
        src = 8'h02; tick(2); src = 8'h00;
        wr(3'd0, 8'h02);
        rd("coll_pend", 3'd0, 8'h02);

        wr(3'd5, 8'h02); tick(3);
        nmi_src = 1; tick(2); nmi_src = 0;
        wr(3'd6, 8'h01);
        rd("coll_nmist", 3'd6, 8'h01);
        tick(1);
        chk("coll_nmi", {7'd0, nmi}, 8'h01);
        wr(3'd6, 8'h01); tick(1);
        chk("coll_nmi_clr", {7'd0, nmi}, 8'h00);

        tick(3);
        nmi_src = 1; tick(3);
        rd("nmi_st", 3'd6, 8'h01);
        chk("nmi_early", {7'd0, nmi}, 8'h00);
        tick(1);
        chk("nmi_set", {7'd0, nmi}, 8'h01);
        nmi_src = 0; tick(3); nmi_src = 1; tick(4);
        chk("nmi_absorb", {7'd0, nmi}, 8'h01);
        rd("nmi_absorb_st", 3'd6, 8'h01);
        nmi_src = 0;
        wr(3'd6, 8'h01);
        rd("nmi_w1c", 3'd6, 8'h00);
        tick(1);
        chk("nmi_clr", {7'd0, nmi}, 8'h00);
        wr(3'd5, 8'h00); tick(3);
        nmi_src = 1; tick(4);
        rd("nmi_disabled", 3'd6, 8'h00);
        chk("nmi_disabled_line", {7'd0, nmi}, 8'h00);
        nmi_src = 0;

        wr(3'd1, 8'h02); wr(3'd5, 8'h01); tick(1);
        chk("mid_irq", {7'd0, irq}, 8'h01);
        #2 reset_ = 0; src = 8'h10;
        #1;
        chk("async_irq", {7'd0, irq}, 8'h00);
        tick(2);
        reset_ = 1;
        rd("post_reset_mask", 3'd1, 8'h00);
        tick(3);
        rd("post_reset_lvl", 3'd0, 8'h10);
        src = 8'h00;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
